// File: rtl/mem_bus_arbiter.sv
// Shares one SRAM-like bus between the fetch port and the load/store port.
// One transaction at a time; data has priority, bounded by a starvation streak counter.
//
// state | meaning
// IDLE  | no transaction; combinational arbitration and grant
// ADDR  | bus_req high, waiting for bus_addr_ok
// DATA  | address accepted, waiting for bus_data_ok
module mem_bus_arbiter #(
    parameter int unsigned MAX_DATA_STREAK = 4,
    parameter int unsigned ADDR_W          = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              inst_req,
    input  logic [ADDR_W-1:0] inst_addr,
    output logic              inst_addr_ok,
    output logic              inst_data_ok,
    output logic [31:0]       inst_rdata,
    input  logic              data_req,
    input  logic              data_wr,
    input  logic [1:0]        data_size,
    input  logic [ADDR_W-1:0] data_addr,
    input  logic [31:0]       data_wdata,
    output logic              data_addr_ok,
    output logic              data_data_ok,
    output logic [31:0]       data_rdata,
    output logic              bus_req,
    output logic              bus_wr,
    output logic [1:0]        bus_size,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [31:0]       bus_wdata,
    input  logic              bus_addr_ok,
    input  logic              bus_data_ok,
    input  logic [31:0]       bus_rdata,
    output logic              busy
);

    typedef enum logic [1:0] {IDLE, ADDR, DATA} state_e;

    localparam logic [3:0] STREAK_MAX = 4'(MAX_DATA_STREAK);

    state_e            state_q, state_d;
    logic              owner_inst_q, owner_inst_d;
    logic [3:0]        streak_q, streak_d;
    logic              bus_wr_q, bus_wr_d;
    logic [1:0]        bus_size_q, bus_size_d;
    logic [ADDR_W-1:0] bus_addr_q, bus_addr_d;
    logic [31:0]       bus_wdata_q, bus_wdata_d;
    logic              grant_inst, grant_data, resp;

    always_comb begin
        state_d      = state_q;
        owner_inst_d = owner_inst_q;
        streak_d     = streak_q;
        bus_wr_d     = bus_wr_q;
        bus_size_d   = bus_size_q;
        bus_addr_d   = bus_addr_q;
        bus_wdata_d  = bus_wdata_q;
        grant_inst   = 1'b0;
        grant_data   = 1'b0;
        resp         = 1'b0;

        unique case (state_q)
            IDLE: begin
                // Pulses are gated by rst_n so every output reads 0 during reset.
                grant_inst = rst_n && inst_req && (!data_req || streak_q == STREAK_MAX);
                grant_data = rst_n && data_req && !grant_inst;
                if (grant_inst) begin
                    state_d      = ADDR;
                    owner_inst_d = 1'b1;
                    streak_d     = 4'd0;
                    bus_wr_d     = 1'b0;
                    bus_size_d   = 2'd2;
                    bus_addr_d   = inst_addr;
                    bus_wdata_d  = 32'd0;
                end else if (grant_data) begin
                    state_d      = ADDR;
                    owner_inst_d = 1'b0;
                    if (!inst_req)
                        streak_d = 4'd0;
                    else if (streak_q != STREAK_MAX)
                        streak_d = streak_q + 4'd1;
                    bus_wr_d     = data_wr;
                    bus_size_d   = data_size;
                    bus_addr_d   = data_addr;
                    bus_wdata_d  = data_wdata;
                end
            end
            ADDR: begin
                if (bus_addr_ok)
                    state_d = DATA;
            end
            DATA: begin
                if (bus_data_ok) begin
                    state_d = IDLE;
                    resp    = rst_n;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            owner_inst_q <= 1'b0;
            streak_q     <= 4'd0;
            bus_wr_q     <= 1'b0;
            bus_size_q   <= 2'd0;
            bus_addr_q   <= '0;
            bus_wdata_q  <= 32'd0;
        end else begin
            state_q      <= state_d;
            owner_inst_q <= owner_inst_d;
            streak_q     <= streak_d;
            bus_wr_q     <= bus_wr_d;
            bus_size_q   <= bus_size_d;
            bus_addr_q   <= bus_addr_d;
            bus_wdata_q  <= bus_wdata_d;
        end
    end

    assign inst_addr_ok = grant_inst;
    assign data_addr_ok = grant_data;
    assign inst_data_ok = resp && owner_inst_q;
    assign data_data_ok = resp && !owner_inst_q;
    // Store completions carry no read data.
    assign inst_rdata   = inst_data_ok ? bus_rdata : 32'd0;
    assign data_rdata   = (data_data_ok && !bus_wr_q) ? bus_rdata : 32'd0;

    assign bus_req   = (state_q == ADDR);
    assign bus_wr    = bus_wr_q;
    assign bus_size  = bus_size_q;
    assign bus_addr  = bus_addr_q;
    assign bus_wdata = bus_wdata_q;
    assign busy      = (state_q != IDLE);

endmodule

// File: doc/mem_bus_arbiter.md
Name: mem_bus_arbiter

Overview:
- Shares one SRAM-like memory bus between the instruction-fetch port and the data (load/store) port.
- The bus is the same interlayer that supplies mem_data and the ready handshake to the write-back stage.
- Only one transaction is outstanding at a time. Data has priority, and a streak counter bounds instruction starvation.
- Sits between the pipeline stages and the bus bridge, inside the CPU core.

Parameters:
- MAX_DATA_STREAK, 4: consecutive contended data grants allowed before inst is forced to win (1..15).
- ADDR_W, 32: address width.

Ports:
- clk  in  1  core clock
- rst_n  in  1  reset, synchronous, active-low
- inst_req  in  1  fetch request; held until inst_addr_ok
- inst_addr  in  ADDR_W  fetch address (read-only port, word size)
- inst_addr_ok  out  1  fetch request accepted (1-cycle pulse)
- inst_data_ok  out  1  fetch data valid (1-cycle pulse)
- inst_rdata  out  32  fetch data; 0 when inst_data_ok=0
- data_req  in  1  load/store request; held until data_addr_ok
- data_wr  in  1  1=store, 0=load
- data_size  in  2  0=byte, 1=half, 2=word
- data_addr  in  ADDR_W  load/store address
- data_wdata  in  32  store data
- data_addr_ok  out  1  data request accepted (1-cycle pulse)
- data_data_ok  out  1  load data valid / store done (1-cycle pulse)
- data_rdata  out  32  load data; 0 when data_data_ok=0
- bus_req  out  1  bus request
- bus_wr  out  1  latched wr
- bus_size  out  2  latched size (inst=2)
- bus_addr  out  ADDR_W  latched address
- bus_wdata  out  32  latched wdata (0 for inst)
- bus_addr_ok  in  1  bus accepted request
- bus_data_ok  in  1  bus response
- bus_rdata  in  32  bus read data
- busy  out  1  state != IDLE

Behaviour:
- Reset (rst_n=0 at posedge):
  - state=IDLE, owner=data, streak=0, all bus_* registers 0.
  - Every output is 0.
  - A transaction in flight is dropped; the bus bridge shares the reset.
- State IDLE, arbitration is combinational:
  - Both requesting, streak<MAX_DATA_STREAK: data wins.
  - Both requesting, streak==MAX_DATA_STREAK: inst wins.
  - Single requester: it wins.
  - In the same cycle, the winner's *_addr_ok=1. At the posedge its fields are latched into bus_* (inst: wr=0, size=2, wdata=0), owner is recorded, and state goes to ADDR.
  - No request: stay in IDLE, no pulse.
- Streak update, on each grant:
  - Data granted while inst_req=1: streak+1.
  - Data granted with inst_req=0: streak=0.
  - Inst granted: streak=0.
  - streak never exceeds MAX_DATA_STREAK.
- State ADDR:
  - bus_req=1; fields stay stable.
  - bus_addr_ok=1 at posedge: state goes to DATA and bus_req drops next cycle.
  - Otherwise hold.
- State DATA:
  - bus_req=0.
  - bus_data_ok=1: owner's *_data_ok=1 and *_rdata=bus_rdata, combinationally in the same cycle. State goes to IDLE at the posedge.
  - The non-owner port sees nothing.
- Stray inputs: bus_addr_ok outside ADDR and bus_data_ok outside DATA are ignored, with no output pulse.
- Pulse rules: *_addr_ok is only ever asserted in IDLE, so at most one per transaction. A new grant happens earliest in the cycle after the data_ok cycle.
- Minimum latency:
  - req seen at cycle 0: addr_ok at cycle 0, bus_req at cycle 1.
  - bus_addr_ok at cycle 1 and bus_data_ok at cycle 2 give requester data_ok at cycle 2.
  - Back-to-back throughput: one transaction per 3 cycles.
- Requester protocol: a requester dropping req before addr_ok is legal and simply not granted. Fields changing while req=1 before addr_ok are sampled only in the grant cycle.
- Stores: data_data_ok pulses on bus_data_ok and data_rdata=0 (the bus_rdata gating applies to loads only).
- Widths: streak counter is 4 bits; bus_rdata is passed through unmodified. Byte/half alignment stays in the write-back stage.

Test Plan:
- Reset, then inst_req=1 addr=0xBFC00000, bus acks addr_ok at cycle 1 and data_ok at cycle 2 with rdata=0x3C080001 -> inst_addr_ok at c0, bus_req=1 only at c1, inst_data_ok=1 with inst_rdata=0x3C080001 at c2, busy 0 at c3.
- inst_req and data_req both held, each bus transaction acked immediately -> grant order D,D,D,D,I,D,D,D,D,I (MAX_DATA_STREAK=4).
- Store data_wr=1 size=0 addr=0x1003 wdata=0xA5, bus stalls addr_ok 3 cycles -> bus_req=1 for 4 cycles with bus_size=0, bus_addr=0x1003, bus_wdata=0xA5; data_data_ok pulses once, data_rdata=0.
- Spurious bus_data_ok in IDLE and in ADDR, plus bus_addr_ok in DATA -> no *_data_ok or *_addr_ok pulse, state unchanged.
- rst_n=0 asserted in DATA with bus_data_ok arriving the same cycle -> no data_ok pulse after the edge, all outputs 0, streak=0, next request granted normally.
- data_req only, 6 back-to-back loads -> streak stays 0, a grant every 3 cycles, inst_* outputs stay 0 throughout.
